// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-unit signal bundle: stage register addresses and controls in,
// forwarding selects, stage enables/flushes and performance counters out.
interface pipe_hazard_ctrl_if #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
);
    logic [RA_W-1:0]  id_rs1, id_rs2;
    logic             id_use_rs1, id_use_rs2;
    logic [RA_W-1:0]  ex_rs1, ex_rs2, ex_rd;
    logic             ex_mem_read, ex_redirect;
    logic [RA_W-1:0]  mem_rd;
    logic             mem_reg_write;
    logic [RA_W-1:0]  wb_rd;
    logic             wb_reg_write;
    logic             mem_busy;
    logic [1:0]       fwd_a, fwd_b;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic             if_id_flush, id_ex_flush;
    logic             stall_active;
    logic [CNT_W-1:0] stall_cycles, flush_events, freeze_cycles;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
               ex_mem_read, ex_redirect, mem_rd, mem_reg_write, wb_rd, wb_reg_write, mem_busy,
        input  fwd_a, fwd_b, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, stall_active, stall_cycles, flush_events, freeze_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
               ex_mem_read, ex_redirect, mem_rd, mem_reg_write, wb_rd, wb_reg_write, mem_busy,
        output fwd_a, fwd_b, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, stall_active, stall_cycles, flush_events, freeze_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/control unit for a 5-stage RISC-V pipeline: EX forwarding, load-use stall
// sequencing, redirect flush, memory freeze and saturating performance counters.
module pipe_hazard_ctrl #(
    parameter int RA_W      = 5,
    parameter int LU_STALLS = 1,
    parameter int CNT_W     = 32
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic {IDLE, STALL} state_t;

    localparam logic [2:0] LU_INIT = 3'(LU_STALLS - 1);

    state_t           state;
    logic [2:0]       remaining;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;
    logic             freeze, redirect, hazard, stall_req, stall_act;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic             if_id_flush, id_ex_flush;

    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs,
                                           input logic [RA_W-1:0] m_rd, input logic m_we,
                                           input logic [RA_W-1:0] w_rd, input logic w_we);
        if (m_we && m_rd != '0 && m_rd == rs)      return 2'b01;
        else if (w_we && w_rd != '0 && w_rd == rs) return 2'b10;
        else                                       return 2'b00;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
        return (inc && c != '1) ? c + 1'b1 : c;
    endfunction

    always_comb begin
        freeze    = bus.mem_busy;
        redirect  = bus.ex_redirect && !freeze;
        hazard    = (state == IDLE) && bus.ex_mem_read && (bus.ex_rd != '0) &&
                    ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
                     (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
        stall_req = (state == STALL) || hazard;
        // A stall held by a freeze is still in progress; a redirect cancels it.
        stall_act = rst_n && stall_req && !bus.ex_redirect;
    end

    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (rst_n) begin
            if (freeze) begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
                mem_wb_en = 1'b0;
            end else if (bus.ex_redirect) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (stall_req) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            remaining  <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            freeze_cnt <= sat_inc(freeze_cnt, freeze);
            stall_cnt  <= sat_inc(stall_cnt, stall_act && !freeze);
            flush_cnt  <= sat_inc(flush_cnt, redirect);
            if (!freeze) begin
                if (bus.ex_redirect) begin
                    state     <= IDLE;
                    remaining <= '0;
                end else if (state == IDLE) begin
                    if (hazard && LU_STALLS > 1) begin
                        state     <= STALL;
                        remaining <= LU_INIT;
                    end
                end else if (remaining == 3'd1) begin
                    state     <= IDLE;
                    remaining <= '0;
                end else begin
                    remaining <= remaining - 3'd1;
                end
            end
        end
    end

    assign bus.fwd_a         = rst_n ? fwd_sel(bus.ex_rs1, bus.mem_rd, bus.mem_reg_write,
                                               bus.wb_rd, bus.wb_reg_write) : 2'b00;
    assign bus.fwd_b         = rst_n ? fwd_sel(bus.ex_rs2, bus.mem_rd, bus.mem_reg_write,
                                               bus.wb_rd, bus.wb_reg_write) : 2'b00;
    assign bus.pc_en         = pc_en;
    assign bus.if_id_en      = if_id_en;
    assign bus.id_ex_en      = id_ex_en;
    assign bus.ex_mem_en     = ex_mem_en;
    assign bus.mem_wb_en     = mem_wb_en;
    assign bus.if_id_flush   = if_id_flush;
    assign bus.id_ex_flush   = id_ex_flush;
    assign bus.stall_active  = stall_act;
    assign bus.stall_cycles  = stall_cnt;
    assign bus.flush_events  = flush_cnt;
    assign bus.freeze_cycles = freeze_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: two controllers share stimulus, one with LU_STALLS=1/CNT_W=4 and
// one with LU_STALLS=3/CNT_W=32.
module tb_pipe_hazard_ctrl;
    logic       clk, rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect;
    logic       mem_reg_write, wb_reg_write, mem_busy;
    int         vectors = 0;
    int         errs = 0;

    pipe_hazard_ctrl_if #(.RA_W(5), .CNT_W(4))  ifa ();
    pipe_hazard_ctrl_if #(.RA_W(5), .CNT_W(32)) ifb ();

    assign ifa.id_rs1 = id_rs1;          assign ifb.id_rs1 = id_rs1;
    assign ifa.id_rs2 = id_rs2;          assign ifb.id_rs2 = id_rs2;
    assign ifa.id_use_rs1 = id_use_rs1;  assign ifb.id_use_rs1 = id_use_rs1;
    assign ifa.id_use_rs2 = id_use_rs2;  assign ifb.id_use_rs2 = id_use_rs2;
    assign ifa.ex_rs1 = ex_rs1;          assign ifb.ex_rs1 = ex_rs1;
    assign ifa.ex_rs2 = ex_rs2;          assign ifb.ex_rs2 = ex_rs2;
    assign ifa.ex_rd = ex_rd;            assign ifb.ex_rd = ex_rd;
    assign ifa.ex_mem_read = ex_mem_read; assign ifb.ex_mem_read = ex_mem_read;
    assign ifa.ex_redirect = ex_redirect; assign ifb.ex_redirect = ex_redirect;
    assign ifa.mem_rd = mem_rd;          assign ifb.mem_rd = mem_rd;
    assign ifa.mem_reg_write = mem_reg_write; assign ifb.mem_reg_write = mem_reg_write;
    assign ifa.wb_rd = wb_rd;            assign ifb.wb_rd = wb_rd;
    assign ifa.wb_reg_write = wb_reg_write; assign ifb.wb_reg_write = wb_reg_write;
    assign ifa.mem_busy = mem_busy;      assign ifb.mem_busy = mem_busy;

    pipe_hazard_ctrl #(.RA_W(5), .LU_STALLS(1), .CNT_W(4))  dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    pipe_hazard_ctrl #(.RA_W(5), .LU_STALLS(3), .CNT_W(32)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, stall_active}
    localparam logic [7:0] RUN = 8'hF8, STL = 8'h3B, RDR = 8'hFE, FRZ = 8'h00, FRZ_STL = 8'h01;

    function automatic logic [7:0] ctl_a();
        return {ifa.pc_en, ifa.if_id_en, ifa.id_ex_en, ifa.ex_mem_en, ifa.mem_wb_en,
                ifa.if_id_flush, ifa.id_ex_flush, ifa.stall_active};
    endfunction

    function automatic logic [7:0] ctl_b();
        return {ifb.pc_en, ifb.if_id_en, ifb.id_ex_en, ifb.ex_mem_en, ifb.mem_wb_en,
                ifb.if_id_flush, ifb.id_ex_flush, ifb.stall_active};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    task automatic set_hazard(input logic on);
        ex_mem_read = on;
        ex_rd       = 5'd7;
        id_rs2      = 5'd7;
        id_use_rs2  = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect} = '0;
        {mem_reg_write, wb_reg_write} = '0;
        mem_busy = 1'b1;

        #2;
        chk("reset_ctl_b", ctl_b(), RUN);
        chk("reset_ctl_a", ctl_a(), RUN);
        chk("reset_fwd", {ifb.fwd_a, ifb.fwd_b}, 4'b0000);
        chk("reset_cnt_b", {ifb.stall_cycles, ifb.flush_events, ifb.freeze_cycles}, 96'd0);
        cyc();
        chk("reset_hold_freeze", ifb.freeze_cycles, 32'd0);
        rst_n = 1'b1;
        mem_busy = 1'b0;
        #1;
        chk("post_reset_ctl", ctl_b(), RUN);

        ex_rs1 = 5'd5; ex_rs2 = 5'd5;
        mem_rd = 5'd5; mem_reg_write = 1'b1;
        wb_rd = 5'd5;  wb_reg_write = 1'b1;
        #1;
        chk("fwd_a_mem_prio", ifb.fwd_a, 2'b01);
        chk("fwd_b_mem_prio", ifb.fwd_b, 2'b01);
        mem_reg_write = 1'b0;
        #1;
        chk("fwd_a_wb", ifb.fwd_a, 2'b10);
        ex_rs1 = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0; mem_reg_write = 1'b1;
        ex_rs2 = 5'd9;
        #1;
        chk("fwd_a_x0", ifb.fwd_a, 2'b00);
        chk("fwd_b_none", ifb.fwd_b, 2'b00);
        wb_rd = 5'd9; mem_rd = 5'd9; mem_reg_write = 1'b0;
        #1;
        chk("fwd_b_wb", ifb.fwd_b, 2'b10);
        {ex_rs1, ex_rs2, mem_rd, wb_rd, mem_reg_write, wb_reg_write} = '0;

        cyc();
        set_hazard(1'b1);
        #1;
        chk("lu_c0_a", ctl_a(), STL);
        chk("lu_c0_b", ctl_b(), STL);
        cyc();
        ex_mem_read = 1'b0;
        #1;
        chk("lu1_done_a", ctl_a(), RUN);
        chk("lu1_cnt_a", ifa.stall_cycles, 4'd1);
        chk("lu3_c1_b", ctl_b(), STL);
        cyc();
        chk("lu3_c2_b", ctl_b(), STL);
        cyc();
        chk("lu3_done_b", ctl_b(), RUN);
        chk("lu3_cnt_b", ifb.stall_cycles, 32'd3);

        ex_mem_read = 1'b1; id_use_rs2 = 1'b0;
        #1;
        chk("no_use_rs2_a", ctl_a(), RUN);
        chk("no_use_rs2_b", ctl_b(), RUN);
        ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        #1;
        chk("ld_x0_b", ctl_b(), RUN);
        cyc();
        chk("no_stall_cnt_b", ifb.stall_cycles, 32'd3);
        {ex_mem_read, id_use_rs1, id_use_rs2, id_rs1, id_rs2, ex_rd} = '0;

        pulse_reset();
        set_hazard(1'b1);
        #1;
        chk("frz_c0", ctl_b(), STL);
        cyc();
        ex_mem_read = 1'b0;
        #1;
        chk("frz_c1", ctl_b(), STL);
        cyc();
        mem_busy = 1'b1;
        #1;
        chk("frz_c2", ctl_b(), FRZ_STL);
        cyc();
        chk("frz_c3", ctl_b(), FRZ_STL);
        cyc();
        mem_busy = 1'b0;
        #1;
        chk("frz_c4", ctl_b(), STL);
        cyc();
        chk("frz_c5", ctl_b(), RUN);
        chk("frz_stall_cnt", ifb.stall_cycles, 32'd3);
        chk("frz_freeze_cnt", ifb.freeze_cycles, 32'd2);

        pulse_reset();
        set_hazard(1'b1);
        #1;
        chk("rdr_c0", ctl_b(), STL);
        cyc();
        ex_mem_read = 1'b0; ex_redirect = 1'b1;
        #1;
        chk("rdr_c1", ctl_b(), RDR);
        cyc();
        ex_redirect = 1'b0;
        #1;
        chk("rdr_c2", ctl_b(), RUN);
        chk("rdr_flush_cnt", ifb.flush_events, 32'd1);
        chk("rdr_stall_cnt", ifb.stall_cycles, 32'd1);
        ex_redirect = 1'b1; mem_busy = 1'b1;
        #1;
        chk("rdr_frozen", ctl_b(), FRZ);
        cyc();
        ex_redirect = 1'b0; mem_busy = 1'b0;
        #1;
        chk("rdr_frozen_cnt", ifb.flush_events, 32'd1);

        pulse_reset();
        set_hazard(1'b1);
        cyc();
        ex_mem_read = 1'b0;
        #1;
        chk("arst_pre", ctl_b(), STL);
        rst_n = 1'b0;
        #1;
        chk("arst_stall_active", ifb.stall_active, 1'b0);
        chk("arst_ctl", ctl_b(), RUN);
        chk("arst_cnt", {ifb.stall_cycles, ifb.flush_events, ifb.freeze_cycles}, 96'd0);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("arst_release", ctl_b(), RUN);
        cyc();
        chk("arst_after_edge", ctl_b(), RUN);
        chk("arst_after_cnt", ifb.stall_cycles, 32'd0);

        pulse_reset();
        {id_use_rs2, id_rs2, ex_rd} = '0;
        mem_busy = 1'b1;
        #1;
        chk("sat_ctl", ctl_a(), FRZ);
        repeat (20) cyc();
        chk("sat_a", ifa.freeze_cycles, 4'd15);
        chk("nosat_b", ifb.freeze_cycles, 32'd20);
        mem_busy = 1'b0;
        cyc();
        chk("sat_hold_a", ifa.freeze_cycles, 4'd15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
